buffer_ctrl: RTL

- Sequencer that drives the three-bank `buffer` datapath (RAM_A/B/C, 32x8 each) as a rotating triple buffer.
- Writer side fills one bank with incoming samples in frames of DEPTH words; reader side drains completed banks in fill order.
- Generates all wren/rden/rdadd/wradd for the three banks, plus the output bank select and valid/last strobes that qualify the RAM q buses.

---
 rtl/buffer_pkg.sv | 16 +
 rtl/buffer_rd_seq.sv | 76 +++++++
 rtl/buffer_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared types and constants for the triple-buffer sequencer
package buffer_pkg;
   localparam int DEPTH_DEF = 32;
   localparam int AW_DEF    = 5;
   localparam int NBANK     = 3;

   typedef logic [1:0] bank_idx_t;

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
   typedef enum logic [1:0] {W_WAIT_SOF, W_FILL, W_DROP} wr_state_t;
   typedef enum logic {R_IDLE, R_BURST} rd_state_t;

   function automatic bank_idx_t next_bank(input bank_idx_t b);
      return (b == bank_idx_t'(NBANK - 1)) ? bank_idx_t'(0) : b + 2'd1;
   endfunction
endpackage

// File: rtl/buffer_rd_seq.sv
// rtl/buffer_rd_seq.sv - reader FSM draining full banks plus q-alignment pipeline
module buffer_rd_seq
   import buffer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             out_ready,
   input  logic             bank_full,
   output bank_idx_t        rbank,
   output logic             start,
   output logic             freed,
   output logic [NBANK-1:0] rden,
   output logic [AW-1:0]    rdadd [NBANK],
   output bank_idx_t        out_sel,
   output logic             out_valid,
   output logic             out_last
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   rd_state_t     rstate;
   logic [AW-1:0] rcnt;
   bank_idx_t     issue_bank;
   logic          issue_last;

   always_comb begin
      start = (rstate == R_IDLE) && bank_full;
      freed = (rstate == R_BURST) && out_ready && (rcnt == LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rstate     <= R_IDLE;
         rbank      <= '0;
         rcnt       <= '0;
         rden       <= '0;
         issue_bank <= '0;
         issue_last <= 1'b0;
         out_sel    <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         for (int i = 0; i < NBANK; i++) rdadd[i] <= '0;
      end else begin
         rden       <= '0;
         issue_last <= 1'b0;
         // q trails rden by one cycle, so the qualifiers are the issue-side flags delayed once
         out_valid  <= |rden;
         out_last   <= issue_last;
         out_sel    <= issue_bank;
         case (rstate)
            R_IDLE: begin
               if (bank_full) begin
                  rcnt   <= '0;
                  rstate <= R_BURST;
               end
            end
            R_BURST: begin
               if (out_ready) begin
                  rden[rbank]  <= 1'b1;
                  rdadd[rbank] <= rcnt;
                  issue_bank   <= rbank;
                  issue_last   <= (rcnt == LAST);
                  rcnt         <= rcnt + 1'b1;
                  if (rcnt == LAST) begin
                     rbank  <= next_bank(rbank);
                     rstate <= R_IDLE;
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/buffer_ctrl.sv
// rtl/buffer_ctrl.sv - triple-buffer sequencer: writer FSM, bank states, RAM controls
module buffer_ctrl
   import buffer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic          out_ready,
   output logic          rama_wren,
   output logic          ramb_wren,
   output logic          ramc_wren,
   output logic          rama_rden,
   output logic          ramb_rden,
   output logic          ramc_rden,
   output logic [AW-1:0] rama_wradd,
   output logic [AW-1:0] ramb_wradd,
   output logic [AW-1:0] ramc_wradd,
   output logic [AW-1:0] rama_rdadd,
   output logic [AW-1:0] ramb_rdadd,
   output logic [AW-1:0] ramc_rdadd,
   output logic [1:0]    out_sel,
   output logic          out_valid,
   output logic          out_last,
   output logic          overflow
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   bank_state_t      bstate [NBANK];
   wr_state_t        wstate;
   bank_idx_t        wbank;
   logic [AW-1:0]    wcnt;
   logic [NBANK-1:0] wren;
   logic [AW-1:0]    wradd [NBANK];
   logic [NBANK-1:0] rden;
   logic [AW-1:0]    rdadd [NBANK];
   bank_idx_t        rbank;
   logic             rd_start;
   logic             rd_freed;
   logic             bank_free;
   logic             bank_full;

   always_comb begin
      bank_free = (bstate[wbank] == B_EMPTY);
      bank_full = (bstate[rbank] == B_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wstate   <= W_WAIT_SOF;
         wbank    <= '0;
         wcnt     <= '0;
         wren     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < NBANK; i++) begin
            bstate[i] <= B_EMPTY;
            wradd[i]  <= '0;
         end
      end else begin
         wren     <= '0;
         overflow <= 1'b0;
         // reader only touches FULL/DRAINING banks, writer only EMPTY/FILLING, so no clash
         for (int i = 0; i < NBANK; i++) begin
            if (rd_start && rbank == bank_idx_t'(i)) bstate[i] <= B_DRAINING;
            if (rd_freed && rbank == bank_idx_t'(i)) bstate[i] <= B_EMPTY;
         end
         case (wstate)
            W_WAIT_SOF, W_DROP: begin
               if (in_valid && in_sof && bank_free) begin
                  bstate[wbank] <= B_FILLING;
                  wren[wbank]   <= 1'b1;
                  wradd[wbank]  <= '0;
                  wcnt          <= AW'(1);
                  wstate        <= W_FILL;
               end else if (in_valid && (in_sof || wstate == W_DROP)) begin
                  overflow <= 1'b1;
                  wstate   <= W_DROP;
               end
            end
            W_FILL: begin
               if (in_valid) begin
                  wren[wbank]  <= 1'b1;
                  wradd[wbank] <= wcnt;
                  wcnt         <= wcnt + 1'b1;
                  if (wcnt == LAST) begin
                     bstate[wbank] <= B_FULL;
                     wbank         <= next_bank(wbank);
                     wstate        <= W_WAIT_SOF;
                  end
               end
            end
            default: wstate <= W_WAIT_SOF;
         endcase
      end
   end

   buffer_rd_seq #(.DEPTH(DEPTH), .AW(AW)) u_rd_seq (
      .clk       (clk),
      .reset     (reset),
      .out_ready (out_ready),
      .bank_full (bank_full),
      .rbank     (rbank),
      .start     (rd_start),
      .freed     (rd_freed),
      .rden      (rden),
      .rdadd     (rdadd),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

   assign rama_wren  = wren[0];
   assign ramb_wren  = wren[1];
   assign ramc_wren  = wren[2];
   assign rama_rden  = rden[0];
   assign ramb_rden  = rden[1];
   assign ramc_rden  = rden[2];
   assign rama_wradd = wradd[0];
   assign ramb_wradd = wradd[1];
   assign ramc_wradd = wradd[2];
   assign rama_rdadd = rdadd[0];
   assign ramb_rdadd = rdadd[1];
   assign ramc_rdadd = rdadd[2];
endmodule
